// File: rtl/pcie_scr_pkg.sv
// pcie_scr_pkg: shared symbol constants, scrambler FSM states and polynomial tap mask.
package pcie_scr_pkg;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [15:0] POLY = 16'h0039;
    typedef enum logic [1:0] {SYNC, OSHDR, SKPOS, RUN} scr_state_e;
endpackage

// File: rtl/scramble_ctrl_if.sv
// scramble_ctrl_if: framer-side symbol stream into the scrambler and encoder-side stream out.
interface scramble_ctrl_if;
    logic InValid;
    logic [7:0] InByte;
    logic InCtrl;
    logic InTs;
    logic InDisable;
    logic OutValid;
    logic [7:0] OutByte;
    logic OutCtrl;
    logic [15:0] Lfsr;
    logic SkpErr;
    modport master(output InValid, InByte, InCtrl, InTs, InDisable,
                   input OutValid, OutByte, OutCtrl, Lfsr, SkpErr);
    modport slave(input InValid, InByte, InCtrl, InTs, InDisable,
                  output OutValid, OutByte, OutCtrl, Lfsr, SkpErr);
endinterface

// File: rtl/scramble_lfsr_step.sv
// scramble_lfsr_step: eight serial Galois shifts of the scrambler LFSR and the bit-reversed XOR byte.
module scramble_lfsr_step
    import pcie_scr_pkg::*;
(
    input  logic [15:0] i_lfsr,
    output logic [15:0] o_next,
    output logic [7:0]  o_xor
);
    assign o_xor = {<<{i_lfsr[15:8]}};
    always_comb begin
        o_next = i_lfsr;
        for (int k = 0; k < 8; k++) o_next = {o_next[14:0], 1'b0} ^ (o_next[15] ? POLY : 16'h0000);
    end
endmodule

// File: rtl/scramble_ctrl.sv
// scramble_ctrl: per-lane transmit scrambling controller with COM reseed, SKP hold and framing checks.
module scramble_ctrl
    import pcie_scr_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hFFFF,
    parameter int MAXSKP = 5
) (
    input logic ClkPci,
    input logic ResetPci,
    scramble_ctrl_if.slave bus
);
    scr_state_e r_state;
    logic [15:0] r_lfsr;
    logic [2:0] r_skp_cnt;
    logic r_dis;
    logic r_out_valid;
    logic [7:0] r_out_byte;
    logic r_out_ctrl;
    logic r_skp_err;
    logic [15:0] w_next;
    logic [7:0] w_xor;
    logic w_com;
    logic w_skp;
    logic w_scr;

    scramble_lfsr_step u_step (.i_lfsr(r_lfsr), .o_next(w_next), .o_xor(w_xor));

    assign w_com = bus.InCtrl && bus.InByte == COM;
    assign w_skp = bus.InCtrl && bus.InByte == SKP;
    // a D byte leaving OSHDR/SKPOS enters RUN and is scrambled like any RUN byte
    assign w_scr = !bus.InCtrl && !bus.InTs && r_state != SYNC && !r_dis;

    always_ff @(posedge ClkPci) begin
        if (ResetPci) begin
            r_state <= SYNC;
            r_lfsr <= SEED;
            r_skp_cnt <= '0;
            r_dis <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_byte <= 8'h00;
            r_out_ctrl <= 1'b0;
            r_skp_err <= 1'b0;
        end else begin
            r_out_valid <= bus.InValid;
            r_skp_err <= 1'b0;
            if (bus.InValid) begin
                r_out_ctrl <= bus.InCtrl;
                r_out_byte <= w_scr ? bus.InByte ^ w_xor : bus.InByte;
                if (w_com) begin
                    r_state <= OSHDR;
                    r_lfsr <= SEED;
                    r_dis <= bus.InDisable;
                end else if (w_skp) begin
                    if (r_state == OSHDR) begin
                        r_state <= SKPOS;
                        r_skp_cnt <= 3'd1;
                    end else if (r_state == SKPOS) begin
                        if (r_skp_cnt >= 3'(MAXSKP)) r_skp_err <= 1'b1;
                        else r_skp_cnt <= r_skp_cnt + 3'd1;
                    end else if (r_state == RUN) begin
                        r_skp_err <= 1'b1;
                    end
                end else if (r_state != SYNC) begin
                    r_state <= RUN;
                    r_lfsr <= w_next;
                end
            end
        end
    end

    assign bus.OutValid = r_out_valid;
    assign bus.OutByte = r_out_byte;
    assign bus.OutCtrl = r_out_ctrl;
    assign bus.Lfsr = r_lfsr;
    assign bus.SkpErr = r_skp_err;
endmodule

// File: tb/tb_scramble_ctrl.sv
// tb_scramble_ctrl: directed stimulus with a symbol-level scrambler model checked every cycle.
module tb_scramble_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int n_skperr = 0;
    logic [7:0] got_q[$];

    logic exp_valid, exp_ctrl, exp_err;
    logic [7:0] exp_byte;
    logic [15:0] exp_lfsr;
    logic m_sync, m_dis, m_hdr;
    int m_skps;

    always #5 clk = ~clk;

    scramble_ctrl_if bus();
    scramble_ctrl dut (.ClkPci(clk), .ResetPci(rst), .bus(bus));

    function automatic logic [15:0] adv(input logic [15:0] s);
        for (int i = 0; i < 8; i++) s = s[15] ? ((s << 1) ^ 16'h0039) : (s << 1);
        return s;
    endfunction

    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7 - i];
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // symbol-level reference: COM reseeds, SKP counts, everything else after sync advances
    always @(posedge clk) begin
        if (rst) begin
            exp_valid = 0; exp_byte = 8'h00; exp_ctrl = 0; exp_lfsr = 16'hFFFF; exp_err = 0;
            m_sync = 0; m_dis = 0; m_hdr = 0; m_skps = 0;
        end else begin
            exp_valid = bus.InValid;
            exp_err = 0;
            if (bus.InValid) begin
                exp_ctrl = bus.InCtrl;
                exp_byte = bus.InByte;
                if (bus.InCtrl && bus.InByte == 8'hBC) begin
                    m_sync = 1; m_hdr = 1; m_skps = 0; m_dis = bus.InDisable; exp_lfsr = 16'hFFFF;
                end else if (bus.InCtrl && bus.InByte == 8'h1C) begin
                    if (m_hdr) begin
                        m_skps++;
                        exp_err = m_skps > 5;
                    end else exp_err = m_sync;
                end else if (m_sync) begin
                    m_hdr = 0;
                    if (!bus.InCtrl && !bus.InTs && !m_dis) exp_byte = exp_byte ^ rev(exp_lfsr[15:8]);
                    exp_lfsr = adv(exp_lfsr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("OutValid", 16'(bus.OutValid), 16'(exp_valid));
            check("OutByte", 16'(bus.OutByte), 16'(exp_byte));
            check("OutCtrl", 16'(bus.OutCtrl), 16'(exp_ctrl));
            check("Lfsr", bus.Lfsr, exp_lfsr);
            check("SkpErr", 16'(bus.SkpErr), 16'(exp_err));
            if (bus.OutValid && !bus.OutCtrl) got_q.push_back(bus.OutByte);
            if (bus.SkpErr) n_skperr++;
        end
    end

    task automatic send(input logic v, input logic c, input logic [7:0] b, input logic ts, input logic dis);
        @(negedge clk);
        bus.InValid = v; bus.InCtrl = c; bus.InByte = b; bus.InTs = ts; bus.InDisable = dis;
    endtask

    task automatic d(input logic [7:0] b); send(1, 0, b, 0, 0); endtask
    task automatic com(input logic dis); send(1, 1, 8'hBC, 0, dis); endtask
    task automatic skp(); send(1, 1, 8'h1C, 0, 0); endtask
    task automatic idle(); send(0, 0, 8'h00, 0, 0); endtask
    task automatic settle(); idle(); idle(); @(posedge clk); #1; endtask

    logic [7:0] lit [8] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};

    initial begin
        bus.InValid = 0; bus.InCtrl = 0; bus.InByte = 0; bus.InTs = 0; bus.InDisable = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        check("rst_valid", 16'(bus.OutValid), 16'h0);
        check("rst_byte", 16'(bus.OutByte), 16'h00);
        check("rst_lfsr", bus.Lfsr, 16'hFFFF);
        @(negedge clk); rst = 0;
        // bytes before the first COM pass through
        got_q.delete();
        d(8'h00); d(8'h5A); settle();
        check("pre_n", 16'(got_q.size()), 16'd2);
        check("pre_b0", 16'(got_q[0]), 16'h00);
        check("pre_b1", 16'(got_q[1]), 16'h5A);
        // COM then 16 zero data bytes, with an idle gap
        got_q.delete();
        com(0);
        for (int i = 0; i < 16; i++) begin
            d(8'h00);
            if (i == 3) idle();
        end
        settle();
        check("seq_n", 16'(got_q.size()), 16'd16);
        for (int i = 0; i < 8; i++) check("seq_byte", 16'(got_q[i]), 16'(lit[i]));
        // SKPs after COM hold the LFSR
        got_q.delete();
        com(0); skp(); skp(); skp(); d(8'h00); settle();
        check("skp_data", 16'(got_q[0]), 16'hFF);
        check("skp_lfsr", bus.Lfsr, 16'hE817);
        // TS symbols pass but advance
        got_q.delete();
        com(0);
        for (int i = 0; i < 15; i++) send(1, 0, 8'h4A, 1, 0);
        d(8'h00); settle();
        check("ts_n", 16'(got_q.size()), 16'd16);
        check("ts_byte", 16'(got_q[0]), 16'h4A);
        // disable latched on COM only
        got_q.delete();
        com(1); send(1, 0, 8'h00, 0, 1); d(8'h00); d(8'hAA); com(0); d(8'h00); settle();
        check("dis_b0", 16'(got_q[0]), 16'h00);
        check("dis_b1", 16'(got_q[1]), 16'h00);
        check("dis_b2", 16'(got_q[2]), 16'hAA);
        check("dis_b3", 16'(got_q[3]), 16'hFF);
        // SKP count limit and SKP in RUN
        n_skperr = 0;
        com(0);
        for (int i = 0; i < 6; i++) skp();
        settle();
        check("skp_limit", 16'(n_skperr), 16'd1);
        com(0); d(8'h00); skp(); settle();
        check("skp_run", 16'(n_skperr), 16'd2);
        check("skp_run_lfsr", bus.Lfsr, 16'hE817);
        // reset mid-packet drops the same-cycle byte
        com(0); d(8'h00); d(8'h00);
        send(1, 0, 8'h33, 0, 0);
        rst = 1;
        @(posedge clk); #1;
        check("mrst_valid", 16'(bus.OutValid), 16'h0);
        check("mrst_byte", 16'(bus.OutByte), 16'h00);
        check("mrst_lfsr", bus.Lfsr, 16'hFFFF);
        @(negedge clk); rst = 0; bus.InValid = 0;
        got_q.delete();
        d(8'h00); settle();
        check("mrst_sync", 16'(got_q[0]), 16'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scramble_ctrl.md
# scramble_ctrl

Per-lane transmit scrambling controller for PCIe Gen1/Gen2 8b/10b lanes. It sits between the lane framer and the 8b/10b encoder. It owns the 16-bit scrambler LFSR (G(X) = X^16 + X^5 + X^4 + X^3 + 1) and applies the link-layer rules: reseed on COM, hold on SKP, no scrambling of K symbols or TS symbols, and a scramble-disable that only changes at ordered-set boundaries. The block registers one output byte per accepted input byte and reports framing errors.

## Interface
- SEED, 16'hFFFF, LFSR value loaded on every COM and at reset.
- MAXSKP, 5, maximum SKP symbols accepted after one COM before SkpErr is raised.
- ClkPci  input  1  lane symbol clock.
- ResetPci  input  1  synchronous, active-high reset.
- InValid  input  1  input byte valid this cycle.
- InByte  input  8  unencoded symbol.
- InCtrl  input  1  1 = K symbol, 0 = D symbol.
- InTs  input  1  D symbol belongs to a TS1/TS2 ordered set: not scrambled, but the LFSR advances.
- InDisable  input  1  scrambling disable request, sampled only on COM.
- OutValid  output  1  registered InValid.
- OutByte  output  8  scrambled or passed-through byte.
- OutCtrl  output  1  registered InCtrl.
- Lfsr  output  16  current LFSR state (debug and checker).
- SkpErr  output  1  one-cycle pulse on a SKP that is out of position or over the count limit.

## Operation
- Constants: COM = 8'hBC (K28.5), SKP = 8'h1C (K28.0).
- XOR byte = bit-reverse of Lfsr[15:8]: bit 0 of the XOR byte is Lfsr[15], bit 7 is Lfsr[8].
- Advance = eight serial LFSR shifts in one cycle.
- Per valid input, in priority order:
  - COM: pass through unscrambled; Lfsr ← SEED; latch the disable flag DisLat ← InDisable.
  - SKP: pass through unscrambled; Lfsr held.
  - Any other K symbol: pass through unscrambled; advance.
  - D with InTs=1: pass through unscrambled; advance.
  - D otherwise: OutByte = InByte ^ XOR byte if the state is RUN and DisLat=0, else InByte; advance.
- FSM states:
  - SYNC (reset state): all bytes pass through unscrambled; Lfsr held at SEED. COM → OSHDR.
  - OSHDR: the symbol after COM. SKP → SKPOS with SkpCnt=1. COM → OSHDR. Anything else → RUN.
  - SKPOS: SKP increments SkpCnt; if SkpCnt would exceed MAXSKP, pulse SkpErr and saturate SkpCnt. COM → OSHDR. Any non-SKP → RUN.
  - RUN: COM → OSHDR. A SKP in RUN pulses SkpErr and is still treated as SKP (Lfsr held).
- InValid=0: no state, LFSR or counter change; OutValid=0; OutByte and OutCtrl hold their previous values.
- InDisable changes between COMs have no effect until the next COM.

## Timing
- Latency is 1 cycle. A byte at edge N appears on OutByte at edge N+1, scrambled with the pre-advance LFSR value at edge N.
- Lfsr shows the post-update state in the cycle after the symbol.
- Full throughput: one byte per cycle, no stall.
- Reset values: OutValid=0, OutByte=8'h00, OutCtrl=0, Lfsr=SEED, SkpErr=0, state=SYNC, DisLat=0, SkpCnt=0.
- Reset asserted mid-stream takes priority over a same-cycle input. That input is dropped and OutValid=0 on the next cycle.
- Back-to-back COMs: each COM reseeds; the FSM stays in OSHDR.

## Structure
- Shared package pcie_scr_pkg holds:
  - the COM and SKP constants;
  - the FSM state enum (SYNC, OSHDR, SKPOS, RUN);
  - the polynomial tap mask 16'h0039.
- Sub-module scramble_lfsr_step: combinational 8-shift advance plus the bit-reversed XOR byte. It is shared with the receive descrambler controller.
- Top level holds the FSM, DisLat, SkpCnt (3 bits) and the output registers.

## Test plan
- Reset, then COM followed by 16 D bytes of 8'h00 (InTs=0) → COM output unchanged, then data bytes FF 17 C0 14 B2 E7 02 82 …
- COM, SKP×3, then D 8'h00 → SKPs unchanged, Lfsr stays 16'hFFFF throughout, first data byte out = 8'hFF.
- COM, then 15 D bytes with InTs=1, then D 8'h00 with InTs=0 → the 15 TS bytes pass unchanged and the data byte equals the 16th sequence byte.
- InDisable=1 sampled on a COM, InDisable dropped mid-packet → data passes unscrambled until the next COM; scrambled output resumes only after that COM.
- COM then SKP×6 → SkpErr pulses on the 6th SKP. A SKP in RUN also pulses SkpErr. Lfsr is unchanged in both cases.
- Bytes before the first COM, and ResetPci asserted mid-packet → no scrambling before COM; after reset all outputs return to reset values and the FSM is back in SYNC.
